// File: rtl/icnd2110_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : icnd2110_read_arbiter
// Purpose  : Round-robin read arbiter that lets NUM_PORTS LED output channels
//            share one word-addressed memory read port. Only one memory read
//            is outstanding at a time; each read takes at least 4 cycles
//            (grant, strobe, capture, finish).
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk                 in   single clock, rising edge
//   rst                 in   asynchronous reset, active low
//   req_address         in   packed per-port read addresses (port i at
//                            [i*ADDRESS_BUS_WIDTH +: ADDRESS_BUS_WIDTH])
//   req_request         in   level request per port
//   req_data            out  read data shared by all ports; held until the
//                            next completion
//   req_finished_strobe out  one-cycle completion pulse, one-hot per port
//   mem_address         out  memory read address, latched at grant
//   mem_read_strobe     out  one-cycle read command to memory
//   mem_read_data       in   memory data, valid with mem_read_done
//   mem_read_done       in   one-cycle memory completion pulse
//   busy                out  high whenever a transaction is in progress
//   grant_id            out  current / last granted port
//   timeout_error       out  sticky watchdog flag (optional build only)
// ----------------------------------------------------------------------------
// Build option
//   ICND2110_ARB_TIMEOUT_EN : when defined, a watchdog counts WAIT cycles and
//   forces completion with zero data after TIMEOUT_CYCLES, setting the sticky
//   timeout_error output. When undefined, WAIT waits indefinitely and the
//   timeout_error port does not exist.
// ============================================================================
module icnd2110_read_arbiter #(
  parameter int NUM_PORTS         = 4,
  parameter int ADDRESS_BUS_WIDTH = 12,
  parameter int TIMEOUT_CYCLES    = 64
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [NUM_PORTS*ADDRESS_BUS_WIDTH-1:0] req_address,
  input  logic [NUM_PORTS-1:0]                   req_request,
  output logic [15:0]                            req_data,
  output logic [NUM_PORTS-1:0]                   req_finished_strobe,
  output logic [ADDRESS_BUS_WIDTH-1:0]           mem_address,
  output logic                                   mem_read_strobe,
  input  logic [15:0]                            mem_read_data,
  input  logic                                   mem_read_done,
  output logic                                   busy,
`ifdef ICND2110_ARB_TIMEOUT_EN
  output logic                                   timeout_error,
`endif
  output logic [$clog2(NUM_PORTS)-1:0]           grant_id
);

  localparam int c_IDW = $clog2(NUM_PORTS);
  localparam int c_AW  = ADDRESS_BUS_WIDTH;

  // Elaboration-time parameter sanity checks.
  if (NUM_PORTS < 2 || NUM_PORTS > 8) begin : g_bad_num_ports
    $error("icnd2110_read_arbiter: NUM_PORTS must be 2..8");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("icnd2110_read_arbiter: TIMEOUT_CYCLES must be >= 1");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [c_AW-1:0]        mem_address_q, mem_address_d;
  logic [15:0]            req_data_q, req_data_d;
  logic [c_IDW-1:0]       grant_id_q, grant_id_d;
  logic [c_IDW-1:0]       last_grant_q, last_grant_d;

  // Round-robin search result.
  logic                   w_found;
  logic [c_IDW-1:0]       w_sel;

`ifdef ICND2110_ARB_TIMEOUT_EN
  localparam int c_CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [c_CW-1:0]        wd_cnt_q, wd_cnt_d;
  logic                   timeout_error_q, timeout_error_d;
`endif

  // --------------------------------------------------------------------------
  // Round-robin pick: first requesting port at distance 1..NUM_PORTS above the
  // last grant, wrapping. Distance NUM_PORTS is the last grantee itself, so a
  // port that keeps requesting is re-served only after every other requester.
  // --------------------------------------------------------------------------
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (!w_found && req_request[p] &&
            (p == ((int'(last_grant_q) + k) % NUM_PORTS))) begin
          w_found = 1'b1;
          w_sel   = c_IDW'(p);
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and datapath next values.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    mem_address_d = mem_address_q;
    req_data_d    = req_data_q;
    grant_id_d    = grant_id_q;
    last_grant_d  = last_grant_q;
`ifdef ICND2110_ARB_TIMEOUT_EN
    wd_cnt_d        = wd_cnt_q;
    timeout_error_d = timeout_error_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (w_found) begin
          // Address is captured only here; later req_address changes are
          // invisible to the in-flight read.
          grant_id_d    = w_sel;
          mem_address_d = req_address[int'(w_sel)*c_AW +: c_AW];
          state_d       = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // mem_read_done is deliberately ignored here.
        state_d = S_WAIT;
`ifdef ICND2110_ARB_TIMEOUT_EN
        wd_cnt_d = '0;
`endif
      end
      S_WAIT: begin
        if (mem_read_done) begin
          req_data_d = mem_read_data;
          state_d    = S_DONE;
        end
`ifdef ICND2110_ARB_TIMEOUT_EN
        else if (wd_cnt_q == c_CW'(TIMEOUT_CYCLES - 1)) begin
          // Memory never answered: complete with zero data so the port is
          // not stuck, and flag the event until the next reset.
          req_data_d      = 16'h0000;
          timeout_error_d = 1'b1;
          state_d         = S_DONE;
        end else begin
          wd_cnt_d = wd_cnt_q + 1'b1;
        end
`endif
      end
      S_DONE: begin
        last_grant_d = grant_id_q;
        state_d      = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State registers. last_grant resets to the top port so port 0 wins first.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      mem_address_q <= '0;
      req_data_q    <= 16'h0000;
      grant_id_q    <= '0;
      last_grant_q  <= c_IDW'(NUM_PORTS - 1);
    end else begin
      state_q       <= state_d;
      mem_address_q <= mem_address_d;
      req_data_q    <= req_data_d;
      grant_id_q    <= grant_id_d;
      last_grant_q  <= last_grant_d;
    end
  end

`ifdef ICND2110_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_cnt_q        <= '0;
      timeout_error_q <= 1'b0;
    end else begin
      wd_cnt_q        <= wd_cnt_d;
      timeout_error_q <= timeout_error_d;
    end
  end

  assign timeout_error = timeout_error_q;
`endif

  // --------------------------------------------------------------------------
  // Outputs. Strobes decode straight from the state register, so they are
  // glitch-free one-cycle pulses and at most one completion bit is ever high.
  // --------------------------------------------------------------------------
  assign mem_read_strobe = (state_q == S_ISSUE);
  assign busy            = (state_q != S_IDLE);
  assign mem_address     = mem_address_q;
  assign req_data        = req_data_q;
  assign grant_id        = grant_id_q;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_fin_strobe
    assign req_finished_strobe[i] = (state_q == S_DONE) &&
                                    (grant_id_q == c_IDW'(i));
  end

endmodule
`default_nettype wire

// File: tb/tb_icnd2110_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_icnd2110_read_arbiter
// Purpose  : Directed self-checking bench for icnd2110_read_arbiter with the
//            default configuration (4 ports, 12-bit addresses).
// Revision : 1.0 - initial release
// ============================================================================
module tb_icnd2110_read_arbiter;

  localparam int NP = 4;
  localparam int AW = 12;

  logic            clk;
  logic            rst;
  logic [NP*AW-1:0] req_address;
  logic [NP-1:0]   req_request;
  logic [15:0]     req_data;
  logic [NP-1:0]   req_finished_strobe;
  logic [AW-1:0]   mem_address;
  logic            mem_read_strobe;
  logic [15:0]     mem_read_data;
  logic            mem_read_done;
  logic            busy;
  logic [1:0]      grant_id;
`ifdef ICND2110_ARB_TIMEOUT_EN
  logic            timeout_error;
`endif

  int total;
  int bad;

  icnd2110_read_arbiter #(
    .NUM_PORTS(NP),
    .ADDRESS_BUS_WIDTH(AW),
    .TIMEOUT_CYCLES(64)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_address(req_address),
    .req_request(req_request),
    .req_data(req_data),
    .req_finished_strobe(req_finished_strobe),
    .mem_address(mem_address),
    .mem_read_strobe(mem_read_strobe),
    .mem_read_data(mem_read_data),
    .mem_read_done(mem_read_done),
    .busy(busy),
`ifdef ICND2110_ARB_TIMEOUT_EN
    .timeout_error(timeout_error),
`endif
    .grant_id(grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance until the DUT shows mem_read_strobe (bounded).
  task automatic wait_issue(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (mem_read_strobe) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic do_reset();
    rst           = 1'b0;
    req_request   = '0;
    mem_read_done = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst           = 1'b0;
    req_address   = '0;
    req_request   = '0;
    mem_read_data = 16'h0000;
    mem_read_done = 1'b0;
    tick();
    tick();
    total++;
    if (busy !== 1'b0 || mem_read_strobe !== 1'b0) begin
      $display("FAIL reset_ctrl: busy=%b strobe=%b, expected 0/0", busy, mem_read_strobe);
      bad++;
    end
    total++;
    if (req_finished_strobe !== 4'b0000 || grant_id !== 2'd0) begin
      $display("FAIL reset_fin: fin=%b gid=%0d, expected 0000/0", req_finished_strobe, grant_id);
      bad++;
    end
    total++;
    if (mem_address !== 12'h000 || req_data !== 16'h0000) begin
      $display("FAIL reset_data: addr=%h data=%h, expected 000/0000", mem_address, req_data);
      bad++;
    end
`ifdef ICND2110_ARB_TIMEOUT_EN
    total++;
    if (timeout_error !== 1'b0) begin
      $display("FAIL reset_timeout: got %b expected 0", timeout_error);
      bad++;
    end
`endif
    rst = 1'b1;
  endtask

  // Single read from port 2, 1-cycle memory latency, 4-cycle transaction.
  task automatic test_single();
    req_address[2*AW +: AW] = 12'h005;
    req_request = 4'b0100;
    tick();
    total++;
    if (mem_read_strobe !== 1'b1 || mem_address !== 12'h005 || grant_id !== 2'd2 || busy !== 1'b1) begin
      $display("FAIL single_issue: strobe=%b addr=%h gid=%0d busy=%b, expected 1/005/2/1",
               mem_read_strobe, mem_address, grant_id, busy);
      bad++;
    end
    tick();
    total++;
    if (mem_read_strobe !== 1'b0 || req_finished_strobe !== 4'b0000) begin
      $display("FAIL single_wait: strobe=%b fin=%b, expected 0/0000", mem_read_strobe, req_finished_strobe);
      bad++;
    end
    mem_read_data = 16'hBEEF;
    mem_read_done = 1'b1;
    tick();
    mem_read_done = 1'b0;
    req_request   = 4'b0000;
    total++;
    if (req_finished_strobe !== 4'b0100 || req_data !== 16'hBEEF) begin
      $display("FAIL single_done: fin=%b data=%h, expected 0100/beef", req_finished_strobe, req_data);
      bad++;
    end
    tick();
    total++;
    if (req_finished_strobe !== 4'b0000 || busy !== 1'b0 || req_data !== 16'hBEEF) begin
      $display("FAIL single_after: fin=%b busy=%b data=%h, expected 0000/0/beef",
               req_finished_strobe, busy, req_data);
      bad++;
    end
  endtask

  // All four ports request continuously: grants 0,1,2,3,0,1.
  task automatic test_round_robin();
    bit ok;
    logic [1:0]  exp_id;
    logic [3:0]  exp_fin;
    logic [15:0] exp_data;
    do_reset();
    for (int i = 0; i < NP; i++) req_address[i*AW +: AW] = 12'h100 + 12'(i);
    req_request = 4'b1111;
    for (int n = 0; n < 6; n++) begin
      exp_id   = 2'(n % 4);
      exp_fin  = 4'b0001 << exp_id;
      exp_data = 16'hA000 + 16'(n);
      wait_issue(ok);
      total++;
      if (!ok) begin
        $display("FAIL rr_timeout: no strobe for transaction %0d", n);
        bad++;
      end
      total++;
      if (grant_id !== exp_id || mem_address !== (12'h100 + 12'(exp_id)) || req_finished_strobe !== 4'b0000) begin
        $display("FAIL rr_grant[%0d]: gid=%0d addr=%h fin=%b, expected %0d/%h/0000",
                 n, grant_id, mem_address, req_finished_strobe, exp_id, 12'h100 + 12'(exp_id));
        bad++;
      end
      tick();
      mem_read_data = exp_data;
      mem_read_done = 1'b1;
      tick();
      mem_read_done = 1'b0;
      if (n == 5) req_request = 4'b0000;
      total++;
      if (req_finished_strobe !== exp_fin || req_data !== exp_data) begin
        $display("FAIL rr_done[%0d]: fin=%b data=%h, expected %b/%h",
                 n, req_finished_strobe, req_data, exp_fin, exp_data);
        bad++;
      end
      tick();
    end
  endtask

  // Port 1, 10-cycle latency, request dropped and address changed in WAIT.
  task automatic test_latency_drop();
    bit ok;
    bit err;
    req_address[1*AW +: AW] = 12'h0AA;
    req_request = 4'b0010;
    wait_issue(ok);
    total++;
    if (!ok || grant_id !== 2'd1 || mem_address !== 12'h0AA) begin
      $display("FAIL lat_issue: ok=%b gid=%0d addr=%h, expected 1/1/0aa", ok, grant_id, mem_address);
      bad++;
    end
    tick();
    req_request = 4'b0000;
    req_address[1*AW +: AW] = 12'h0BB;
    err = 1'b0;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (mem_address !== 12'h0AA || req_finished_strobe !== 4'b0000 || busy !== 1'b1) err = 1'b1;
    end
    total++;
    if (err) begin
      $display("FAIL lat_hold: addr=%h fin=%b busy=%b, expected 0aa/0000/1 throughout",
               mem_address, req_finished_strobe, busy);
      bad++;
    end
    mem_read_data = 16'h1234;
    mem_read_done = 1'b1;
    tick();
    mem_read_done = 1'b0;
    total++;
    if (req_finished_strobe !== 4'b0010 || req_data !== 16'h1234 || mem_address !== 12'h0AA) begin
      $display("FAIL lat_done: fin=%b data=%h addr=%h, expected 0010/1234/0aa",
               req_finished_strobe, req_data, mem_address);
      bad++;
    end
    tick();
  endtask

  // Stray mem_read_done in IDLE and in ISSUE must be ignored.
  task automatic test_spurious_done();
    bit ok;
    mem_read_data = 16'hDEAD;
    mem_read_done = 1'b1;
    tick();
    mem_read_done = 1'b0;
    total++;
    if (busy !== 1'b0 || req_finished_strobe !== 4'b0000 || req_data !== 16'h1234) begin
      $display("FAIL spur_idle: busy=%b fin=%b data=%h, expected 0/0000/1234",
               busy, req_finished_strobe, req_data);
      bad++;
    end
    // last grant was port 1, so port 3 alone is granted next.
    req_address[3*AW +: AW] = 12'h333;
    req_request = 4'b1000;
    wait_issue(ok);
    total++;
    if (!ok || grant_id !== 2'd3) begin
      $display("FAIL spur_grant: ok=%b gid=%0d, expected 1/3", ok, grant_id);
      bad++;
    end
    mem_read_data = 16'hDEAD;
    mem_read_done = 1'b1;
    tick();
    mem_read_done = 1'b0;
    tick();
    tick();
    total++;
    if (busy !== 1'b1 || req_finished_strobe !== 4'b0000 || req_data !== 16'h1234) begin
      $display("FAIL spur_issue: busy=%b fin=%b data=%h, expected 1/0000/1234",
               busy, req_finished_strobe, req_data);
      bad++;
    end
    mem_read_data = 16'h3333;
    mem_read_done = 1'b1;
    tick();
    mem_read_done = 1'b0;
    req_request   = 4'b0000;
    total++;
    if (req_finished_strobe !== 4'b1000 || req_data !== 16'h3333) begin
      $display("FAIL spur_done: fin=%b data=%h, expected 1000/3333", req_finished_strobe, req_data);
      bad++;
    end
    tick();
  endtask

  // Reset asserted in WAIT, then a stray done; next request goes to port 0.
  task automatic test_reset_mid_wait();
    bit ok;
    req_address[2*AW +: AW] = 12'h222;
    req_request = 4'b0100;
    wait_issue(ok);
    total++;
    if (!ok || grant_id !== 2'd2) begin
      $display("FAIL rmw_grant: ok=%b gid=%0d, expected 1/2", ok, grant_id);
      bad++;
    end
    tick();
    #2;
    rst = 1'b0;
    #1;
    total++;
    if (busy !== 1'b0 || mem_address !== 12'h000 || req_data !== 16'h0000 || grant_id !== 2'd0 ||
        mem_read_strobe !== 1'b0 || req_finished_strobe !== 4'b0000) begin
      $display("FAIL rmw_async: busy=%b addr=%h data=%h gid=%0d strobe=%b fin=%b, expected all 0",
               busy, mem_address, req_data, grant_id, mem_read_strobe, req_finished_strobe);
      bad++;
    end
    req_request = 4'b0000;
    @(posedge clk);
    #1;
    rst = 1'b1;
    mem_read_data = 16'h5555;
    mem_read_done = 1'b1;
    tick();
    mem_read_done = 1'b0;
    total++;
    if (busy !== 1'b0 || req_finished_strobe !== 4'b0000 || req_data !== 16'h0000) begin
      $display("FAIL rmw_stray: busy=%b fin=%b data=%h, expected 0/0000/0000",
               busy, req_finished_strobe, req_data);
      bad++;
    end
    req_address[0*AW +: AW] = 12'h010;
    req_request = 4'b0101;
    wait_issue(ok);
    total++;
    if (!ok || grant_id !== 2'd0 || mem_address !== 12'h010) begin
      $display("FAIL rmw_next: ok=%b gid=%0d addr=%h, expected 1/0/010", ok, grant_id, mem_address);
      bad++;
    end
    tick();
    mem_read_data = 16'h0F0F;
    mem_read_done = 1'b1;
    tick();
    mem_read_done = 1'b0;
    req_request   = 4'b0000;
    total++;
    if (req_finished_strobe !== 4'b0001 || req_data !== 16'h0F0F) begin
      $display("FAIL rmw_done: fin=%b data=%h, expected 0001/0f0f", req_finished_strobe, req_data);
      bad++;
    end
    tick();
  endtask

`ifdef ICND2110_ARB_TIMEOUT_EN
  // Memory never answers: completion after 64 WAIT cycles with zero data.
  task automatic test_timeout();
    bit ok;
    req_address[1*AW +: AW] = 12'h0C0;
    req_request = 4'b0010;
    wait_issue(ok);
    req_request = 4'b0000;
    for (int i = 0; i < 64; i++) tick();
    total++;
    if (req_finished_strobe !== 4'b0000) begin
      $display("FAIL to_early: fin=%b, expected 0000", req_finished_strobe);
      bad++;
    end
    tick();
    total++;
    if (!ok || req_finished_strobe !== 4'b0010 || req_data !== 16'h0000 || timeout_error !== 1'b1) begin
      $display("FAIL to_done: ok=%b fin=%b data=%h terr=%b, expected 1/0010/0000/1",
               ok, req_finished_strobe, req_data, timeout_error);
      bad++;
    end
    tick();
  endtask
`endif

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_single();
    test_round_robin();
    test_latency_drop();
    test_spurious_done();
    test_reset_mid_wait();
`ifdef ICND2110_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/icnd2110_read_arbiter.md
ICND2110_READ_ARBITER -- requirements
Module: icnd2110_read_arbiter

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 4, number of requesting LED output channels (2..8).
REQ-002 SHALL have parameter ADDRESS_BUS_WIDTH, default 12, width of every word address.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 64, watchdog limit in clk cycles (used only under REQ-030).
REQ-004 SHALL have port clk  input  1  single clock; all logic on posedge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port req_address  input  NUM_PORTS*ADDRESS_BUS_WIDTH  packed per-port read addresses; port i at bits [i*AW +: AW].
REQ-007 SHALL have port req_request  input  NUM_PORTS  level request per port.
REQ-008 SHALL have port req_data  output  16  read data, shared by all ports.
REQ-009 SHALL have port req_finished_strobe  output  NUM_PORTS  one-cycle completion pulse per port.
REQ-010 SHALL have port mem_address  output  ADDRESS_BUS_WIDTH  shared memory read address.
REQ-011 SHALL have port mem_read_strobe  output  1  one-cycle read command to memory.
REQ-012 SHALL have port mem_read_data  input  16  memory data, valid with mem_read_done.
REQ-013 SHALL have port mem_read_done  input  1  one-cycle memory completion pulse, arbitrary latency >=1 cycle.
REQ-014 SHALL have ports busy (1, output, state != IDLE) and grant_id (output, $clog2(NUM_PORTS), current/last granted port).

Function
REQ-015 SHALL implement states IDLE, ISSUE, WAIT, DONE; at most one memory transaction outstanding.
REQ-016 IDLE: if any req_request bit set, SHALL grant the first set port searching upward (wrapping) from last_grant+1, latch its address into mem_address, set grant_id, go ISSUE; else stay IDLE.
REQ-017 ISSUE: SHALL assert mem_read_strobe for exactly this one cycle, then go WAIT.
REQ-018 WAIT: on mem_read_done SHALL register mem_read_data into req_data and go DONE; otherwise stay WAIT.
REQ-019 DONE: SHALL pulse req_finished_strobe[grant_id] for exactly one cycle with req_data valid, update last_grant, return IDLE.
REQ-020 Minimum transaction = 4 cycles (grant, strobe, done-capture, finish) when mem_read_done arrives the cycle after mem_read_strobe.
REQ-021 req_data SHALL hold its value until the next DONE; mem_address SHALL be stable from ISSUE through WAIT.
REQ-022 Request deassertion after grant SHALL NOT abort; the transaction completes and the strobe is delivered.
REQ-023 mem_read_done outside WAIT SHALL be ignored (no state, data or strobe change).
REQ-024 Address sampled only at grant; later req_address changes SHALL NOT affect the in-flight read.
REQ-025 A port requesting continuously SHALL be re-granted only after every other requesting port has been served once (strict round-robin, no starvation).
REQ-026 At most one req_finished_strobe bit SHALL be high in any cycle.

Reset
REQ-027 rst low SHALL immediately force state IDLE, mem_read_strobe 0, req_finished_strobe 0, mem_address 0, req_data 0, grant_id 0, busy 0, timeout_error 0.
REQ-028 After reset, last_grant SHALL equal NUM_PORTS-1 so port 0 has first priority.
REQ-029 Reset during WAIT SHALL discard the transaction; a subsequent stray mem_read_done SHALL be ignored per REQ-023.

Configuration
REQ-030 Macro ICND2110_ARB_TIMEOUT_EN defined: a counter SHALL run in WAIT; on reaching TIMEOUT_CYCLES without mem_read_done, SHALL set sticky output timeout_error, go DONE with req_data = 16'h0000 and still pulse the strobe; timeout_error clears only on reset.
REQ-031 Macro undefined: no counter, no timeout_error port; WAIT waits indefinitely.

Verification
REQ-032 Reset, port 2 requests address 0x005, memory done 1 cycle after strobe with 0xBEEF -> mem_address 0x005, strobe cycle 2, req_finished_strobe = 4'b0100 cycle 4, req_data 0xBEEF.
REQ-033 All 4 ports request continuously -> grant order 0,1,2,3,0,1 with one strobe per transaction, never two overlapping.
REQ-034 Memory latency 10 cycles; port 1 drops request during WAIT and changes address -> original address read, strobe 4'b0010 still delivered.
REQ-035 Spurious mem_read_done in IDLE and in ISSUE -> no strobe, req_data unchanged.
REQ-036 Reset asserted mid-WAIT, then mem_read_done -> all outputs 0, no strobe, next request served normally from port 0.
REQ-037 With ICND2110_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=64, memory never responds -> after 64 WAIT cycles timeout_error=1, req_data 0x0000, strobe to granted port, arbitration continues.
